chip8_mem: RTL
==============

CHIP8_MEM -- requirements
Module: chip8_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning address width; depth = 2**ADDR_W bytes.
REQ-002 SHALL have parameter FONT_BASE, default 12'h050, meaning the first byte address of the 80-byte font image.
REQ-003 SHALL have parameter PROT_TOP, default 12'h200, meaning that addresses below it are write-protected when prot_en=1.
REQ-004 SHALL have port clk, in, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, in, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port prot_en, in, 1 bit: enables write protection.
REQ-007 SHALL have port ready, out, 1 bit: high once font preload is complete.
REQ-008 SHALL have ports cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, ADDR_W), cpu_wdata (in, u8): the CPU access request.
REQ-009 SHALL have ports cpu_rdata (out, u8) and cpu_rvalid (out, 1): the CPU read response.
REQ-010 SHALL have port cpu_err, out, 1 bit: one-cycle pulse when a write is rejected.
REQ-011 SHALL have ports vid_req (in, 1) and vid_addr (in, ADDR_W): the read-only sprite/display port.
REQ-012 SHALL have ports vid_rdata (out, u8) and vid_rvalid (out, 1): the video read response.

Function
REQ-013 SHALL implement a two-state init FSM with states INIT and READY; after reset it SHALL enter INIT with font index 0.
REQ-014 In INIT, SHALL write font byte i to FONT_BASE+i, one byte per cycle for i = 0..79, then move to READY; ready SHALL rise in the cycle after the write of i=79.
REQ-015 In INIT, SHALL ignore cpu_req and vid_req: no writes, rvalid outputs 0, cpu_err 0.
REQ-016 In READY, a CPU read (cpu_req=1, cpu_we=0) SHALL return mem[cpu_addr] on cpu_rdata with cpu_rvalid=1 exactly one cycle later.
REQ-017 In READY, a CPU write SHALL update memory at the clock edge, SHALL produce no cpu_rvalid, and SHALL be visible to any read issued in the next cycle or later.
REQ-018 A CPU write with prot_en=1 and cpu_addr < PROT_TOP SHALL be dropped, and cpu_err SHALL pulse high for one cycle, one cycle after the request.
REQ-019 The video port SHALL return mem[vid_addr] with vid_rvalid=1 one cycle after vid_req, independently of and concurrently with the CPU port.
REQ-020 On a same-cycle CPU write and video read to the same address, the video port SHALL return the old data.
REQ-021 Addresses SHALL be exactly ADDR_W bits, so FONT_BASE+i and all port addresses wrap modulo 2**ADDR_W.
REQ-022 The rdata outputs SHALL hold their last value when the corresponding rvalid=0; back-to-back requests SHALL give one response per cycle.

Reset
REQ-023 While rst=0: ready=0, cpu_rvalid=0, vid_rvalid=0, cpu_err=0, cpu_rdata=0, vid_rdata=0, FSM in INIT with font index 0.
REQ-024 Memory contents outside the font region SHALL NOT be cleared by reset.
REQ-025 Reset asserted mid-INIT or mid-READY SHALL abort any in-flight response, and the preload SHALL restart from index 0 after release.

Structure
REQ-026 The u8 type, the 80-entry standard font constant, the FONT_LEN=80 constant and the init-state enum SHALL live in the shared types package.
REQ-027 SHALL instantiate one sub-module, chip8_font_rom: a combinational lookup from a 7-bit index to a u8 byte, driven from the package constant.
REQ-028 Memory SHALL be a single u8 array of depth 2**ADDR_W with one write/read port and one read port, inferable as simple dual-port block RAM.

Verification
REQ-029 Release reset, wait for ready -> ready rises 81 cycles after release; a CPU read of 0x050 returns 0xF0, 0x051 returns 0x90, 0x09B returns 0xF0, and 0x09F returns 0x80.
REQ-030 With prot_en=1, a CPU write of 0xAA to 0x1FF -> cpu_err pulses once and a read of 0x1FF is unchanged; a write of 0xAA to 0x200 -> no err, and a read of 0x200 returns 0xAA.
REQ-031 In the same cycle, a CPU write of 0x55 to 0x300 and a video read of 0x300 (old value 0x11) -> vid_rdata=0x11; a video read of 0x300 next cycle -> 0x55.
REQ-032 Assert reset at font index 40, then release -> ready stays 0 for 81 more cycles and the font bytes are complete and correct afterwards.
REQ-033 Issue cpu_req during INIT -> no cpu_rvalid and no memory change; issue vid_req in 4 consecutive READY cycles to 0xFFE, 0xFFF, 0x000, 0x001 -> 4 consecutive vid_rvalid pulses with the matching data.

Source files
------------

// File: rtl/chip8_mem_pkg.sv
// ----------------------------------------------------------------------------
// chip8_mem_pkg
// Shared types and constants for the CHIP-8 memory block:
//   u8            - byte type used on every data path
//   FONT_LEN      - number of bytes in the built-in hex font (16 glyphs x 5)
//   FONT_IDX_W    - width of the font byte index
//   init_state_e  - preload FSM states
//   FONT          - the standard CHIP-8 hex font image, glyph 0 first
// ----------------------------------------------------------------------------
package chip8_mem_pkg;

    typedef logic [7:0] u8;

    localparam int FONT_LEN   = 80;
    localparam int FONT_IDX_W = 7;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    localparam u8 FONT [FONT_LEN] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
    };

endpackage

// File: rtl/chip8_font_rom.sv
// ----------------------------------------------------------------------------
// chip8_font_rom
// Combinational lookup of one byte of the built-in hex font.
// Ports:
//   idx  (in,  7 bits) - font byte index, 0..FONT_LEN-1
//   data (out, u8)     - font byte; 0 for indices past the end of the image
// ----------------------------------------------------------------------------
module chip8_font_rom
    import chip8_mem_pkg::*;
(
    input  logic [FONT_IDX_W-1:0] idx,
    output u8                     data
);

    always_comb begin
        data = '0;
        if (int'(idx) < FONT_LEN) begin
            data = FONT[idx];
        end
    end

endmodule

// File: rtl/chip8_mem.sv
// ----------------------------------------------------------------------------
// chip8_mem
// CHIP-8 main memory: 2**ADDR_W bytes with a CPU read/write port and a
// read-only video port. After reset the font image is copied into
// FONT_BASE.. one byte per cycle; until then both ports are ignored.
// Ports:
//   clk        (in)          - clock, rising edge
//   rst        (in)          - asynchronous active-low reset
//   prot_en    (in)          - reject CPU writes below PROT_TOP
//   ready      (out)         - font preload finished, ports live
//   cpu_req    (in)          - CPU access request
//   cpu_we     (in)          - 1 = write, 0 = read
//   cpu_addr   (in, ADDR_W)  - CPU byte address
//   cpu_wdata  (in, u8)      - CPU write data
//   cpu_rdata  (out, u8)     - CPU read data, held between responses
//   cpu_rvalid (out)         - CPU read response, one cycle after request
//   cpu_err    (out)         - one-cycle pulse after a rejected write
//   vid_req    (in)          - video read request
//   vid_addr   (in, ADDR_W)  - video byte address
//   vid_rdata  (out, u8)     - video read data, held between responses
//   vid_rvalid (out)         - video read response, one cycle after request
// ----------------------------------------------------------------------------
module chip8_mem
    import chip8_mem_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] FONT_BASE = 12'h050,
    parameter logic [ADDR_W-1:0] PROT_TOP  = 12'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prot_en,
    output logic              ready,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  u8                 cpu_wdata,
    output u8                 cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output u8                 vid_rdata,
    output logic              vid_rvalid
);

    localparam int DEPTH = 2 ** ADDR_W;

    init_state_e           state_q, state_d;
    logic [FONT_IDX_W-1:0] idx_q, idx_d;
    logic                  init_we;
    logic                  is_ready;
    u8                     font_byte;

    logic                  cpu_wr_req;
    logic                  cpu_wr_blk;
    logic                  cpu_wr_ok;
    logic                  cpu_rd;
    logic                  vid_rd;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    u8                     wr_data;

    u8                     mem [DEPTH];

    u8                     cpu_data_p1;
    logic                  cpu_vld_p1;
    logic                  cpu_err_p1;
    u8                     vid_data_p1;
    logic                  vid_vld_p1;

    chip8_font_rom u_font_rom (
        .idx  (idx_q),
        .data (font_byte)
    );

    // ------------------------------------------------------------------
    // Preload FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        init_we = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                // Gated by rst so a held reset does not keep rewriting byte 0.
                init_we = rst;
                if (idx_q == FONT_IDX_W'(FONT_LEN - 1)) begin
                    state_d = ST_READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    assign is_ready = (state_q == ST_READY);

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    always_comb begin
        cpu_wr_req = is_ready & cpu_req & cpu_we;
        cpu_wr_blk = cpu_wr_req & prot_en & (cpu_addr < PROT_TOP);
        cpu_wr_ok  = cpu_wr_req & ~cpu_wr_blk;
        cpu_rd     = is_ready & cpu_req & ~cpu_we;
        vid_rd     = is_ready & vid_req;
    end

    // The preload and the CPU never write in the same cycle (CPU is
    // ignored during INIT), so port A is a simple mux between them.
    always_comb begin
        wr_en   = init_we | cpu_wr_ok;
        wr_addr = cpu_addr;
        wr_data = cpu_wdata;
        if (init_we) begin
            // Sum is ADDR_W bits wide, so the font image wraps at the top.
            wr_addr = FONT_BASE + ADDR_W'(idx_q);
            wr_data = font_byte;
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset, so contents survive rst outside the font area
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read responses (_p1): registered reads return pre-write data on
    // a same-cycle write to the same address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_data_p1 <= '0;
            cpu_vld_p1  <= 1'b0;
            cpu_err_p1  <= 1'b0;
            vid_data_p1 <= '0;
            vid_vld_p1  <= 1'b0;
        end else begin
            cpu_vld_p1 <= cpu_rd;
            cpu_err_p1 <= cpu_wr_blk;
            vid_vld_p1 <= vid_rd;
            if (cpu_rd) begin
                cpu_data_p1 <= mem[cpu_addr];
            end
            if (vid_rd) begin
                vid_data_p1 <= mem[vid_addr];
            end
        end
    end

    assign ready      = is_ready;
    assign cpu_rdata  = cpu_data_p1;
    assign cpu_rvalid = cpu_vld_p1;
    assign cpu_err    = cpu_err_p1;
    assign vid_rdata  = vid_data_p1;
    assign vid_rvalid = vid_vld_p1;

endmodule
